// File: rtl/wb_port_arbiter.sv
// Round-robin 4:1 write-back port arbiter: combinational one-hot grant, registered wb_* one cycle later.
// stall freezes every register and suppresses the grant; an idle cycle only clears wb_en.
module wb_port_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [4:0]       rd0,
  input  logic [4:0]       rd1,
  input  logic [4:0]       rd2,
  input  logic [4:0]       rd3,
  input  logic             stall,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data
);

  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic             r_en;
  logic [4:0]       r_rd;
  logic [WIDTH-1:0] r_data;

  logic             w_any;
  logic [1:0]       w_idx;
  logic [1:0]       w_cand;
  logic [3:0]       w_gnt;
  logic [4:0]       w_src_rd;
  logic [WIDTH-1:0] w_src_d;

  // Scan from r_ptr upward (mod 4); first asserted request wins.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = 2'd0;
    w_cand = 2'd0;
    w_gnt  = 4'b0000;
    if (!reset && !stall) begin
      for (int k = 0; k < 4; k++) begin
        w_cand = r_ptr + k[1:0];
        if (!w_any && req[w_cand]) begin
          w_any = 1'b1;
          w_idx = w_cand;
        end
      end
    end
    if (w_any) w_gnt[w_idx] = 1'b1;
  end

  always_comb begin
    w_src_rd = rd0;
    w_src_d  = d0;
    case (w_idx)
      2'd1: begin w_src_rd = rd1; w_src_d = d1; end
      2'd2: begin w_src_rd = rd2; w_src_d = d2; end
      2'd3: begin w_src_rd = rd3; w_src_d = d3; end
      default: begin w_src_rd = rd0; w_src_d = d0; end
    endcase
  end

  // A grant to x0 still consumes the slot and advances the pointer, but never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= 2'd0;
      r_sel  <= 2'd0;
      r_en   <= 1'b0;
      r_rd   <= 5'd0;
      r_data <= '0;
    end else if (w_any) begin
      r_ptr  <= w_idx + 2'd1;
      r_sel  <= w_idx;
      r_en   <= |w_src_rd;
      r_rd   <= w_src_rd;
      r_data <= w_src_d;
    end else if (!stall) begin
      r_en   <= 1'b0;
    end
  end

  assign gnt     = w_gnt;
  assign sel     = r_sel;
  assign wb_en   = r_en;
  assign wb_rd   = r_rd;
  assign wb_data = r_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a rule-level round-robin model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        stall;
  logic [63:0] dv [4];
  logic [4:0]  rdv [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what the write-back port should hold after each edge.
  int          m_ptr;
  int          m_sel;
  logic        m_en;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  int          waits [4];
  logic [3:0]  last_gnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .rd0(rdv[0]), .rd1(rdv[1]), .rd2(rdv[2]), .rd3(rdv[3]),
    .stall(stall), .gnt(gnt), .sel(sel), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++) begin
      if (rq[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_en = 1'b0; m_rd = 5'd0; m_data = 64'd0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".sel"},     64'(sel),     64'(m_sel));
    chk({tag, ".wb_en"},   64'(wb_en),   64'(m_en));
    chk({tag, ".wb_rd"},   64'(wb_rd),   64'(m_rd));
    chk({tag, ".wb_data"}, wb_data,      m_data);
  endtask

  // Drive one cycle starting just after a rising edge; ends just after the next one.
  task automatic cycle(input logic [3:0] rq, input logic st);
    int g;
    logic [3:0] eg;
    req = rq;
    stall = st;
    @(negedge clk);
    g  = st ? -1 : pick(rq, m_ptr);
    eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("gnt", 64'(gnt), 64'(eg));
    chk_outputs("hold");
    last_gnt = gnt;
    for (int i = 0; i < 4; i++) begin
      if (!rq[i] || gnt[i]) waits[i] = 0;
      else if (!st && gnt != 4'b0000) waits[i]++;
      if (waits[i] > 3) chk("starve", 64'(waits[i]), 64'd3);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_sel  = g;
      m_rd   = rdv[g];
      m_data = dv[g];
      m_en   = (rdv[g] != 5'd0);
      m_ptr  = (g + 1) % 4;
    end else if (!st) begin
      m_en = 1'b0;
    end
    #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, ".gnt"}, 64'(gnt), 64'd0);
    chk_outputs(tag);
    req = 4'b0000;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pend;
    logic [3:0] rq;
    reset = 1'b1;
    req   = 4'b1111;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv[i]  = 64'h1000 + 64'(i);
      rdv[i] = 5'(i + 1);
    end
    model_reset();
    #1;
    chk("rst.gnt", 64'(gnt), 64'd0);
    chk_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request from requester 2.
    rdv[2] = 5'd5;
    dv[2]  = 64'hAA;
    cycle(4'b0100, 1'b0);
    chk("r27.wb_en", 64'(wb_en), 64'd1);
    chk("r27.wb_rd", 64'(wb_rd), 64'd5);
    chk("r27.wb_data", wb_data, 64'hAA);
    chk("r27.sel", 64'(sel), 64'd2);
    cycle(4'b1000, 1'b0);
    chk("r27.next_sel", 64'(sel), 64'd3);

    // All requesting: strict rotation from pointer 0.
    async_reset("r28rst");
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0);
      chk("r28.sel", 64'(sel), 64'(i % 4));
    end

    // x0 destination: grant consumed, no write.
    rdv[1] = 5'd0;
    cycle(4'b0010, 1'b0);
    chk("r29.wb_en", 64'(wb_en), 64'd0);
    chk("r29.wb_rd", 64'(wb_rd), 64'd0);
    chk("r29.sel", 64'(sel), 64'd1);

    // Stall freezes everything, then grant resumes from the held pointer.
    rdv[2] = 5'd7;
    cycle(4'b0100, 1'b0);
    chk("r30.pre_en", 64'(wb_en), 64'd1);
    repeat (3) cycle(4'b0011, 1'b1);
    chk("r30.frozen_rd", 64'(wb_rd), 64'd7);
    cycle(4'b0011, 1'b0);
    chk("r30.resume_sel", 64'(sel), 64'd0);

    // Pointer at 2 with requesters 0 and 3: 3 wins, then wrap to 0.
    rdv[1] = 5'd9;
    cycle(4'b0010, 1'b0);
    cycle(4'b1001, 1'b0);
    chk("r31.sel3", 64'(sel), 64'd3);
    cycle(4'b1001, 1'b0);
    chk("r31.sel0", 64'(sel), 64'd0);

    // Async reset while a write is pending on the port.
    cycle(4'b0100, 1'b0);
    chk("r32.pre_en", 64'(wb_en), 64'd1);
    async_reset("r32");

    // Randomized traffic: requests stay up until granted.
    pend = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i]  = {$urandom, $urandom};
        rdv[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      rq = pend;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) rq[i] = 1'b1;
      cycle(rq, $urandom_range(0, 4) == 0);
      pend = rq & ~last_gnt;
      if (n == 200) begin
        async_reset("rnd_rst");
        pend = 4'b0000;
      end
    end
    cycle(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of every requester and of the write-back output.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 4, req[i] high = requester i presents a write this cycle.
REQ-005 SHALL have ports d0..d3, input, WIDTH each, write data of requesters 0..3.
REQ-006 SHALL have ports rd0..rd3, input, 5 each, destination register index of requesters 0..3.
REQ-007 SHALL have port stall, input, 1, downstream hold; high = no new grant, outputs frozen.
REQ-008 SHALL have port gnt, output, 4, one-hot combinational grant; gnt[i] high = requester i captured at this edge.
REQ-009 SHALL have port sel, output, 2, registered index of the requester that owns the current output.
REQ-010 SHALL have port wb_en, output, 1, registered register-file write enable.
REQ-011 SHALL have port wb_rd, output, 5, registered destination index.
REQ-012 SHALL have port wb_data, output, WIDTH, registered write data.

Function
REQ-013 SHALL keep a 2-bit round-robin pointer ptr naming the highest-priority requester; priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 SHALL assert gnt[i] for exactly the first requester i in priority order with req[i]=1, when stall=0; otherwise gnt=4'b0000.
REQ-015 SHALL never assert more than one gnt bit; gnt SHALL be 0 whenever req=0 or stall=1.
REQ-016 SHALL, on an edge with grant to i, load sel<=i, wb_rd<=rd_i, wb_data<=d_i (source chosen by sel-equivalent 4:1 selection) and ptr<=(i+1) mod 4.
REQ-017 SHALL, on an edge with grant to i, set wb_en<=1 if rd_i!=0 and wb_en<=0 if rd_i==0 (x0 write discarded; grant still consumed, ptr still advances).
REQ-018 SHALL have latency exactly 1 cycle: data granted at edge N visible on wb_* after edge N.
REQ-019 SHALL, on an edge with stall=0 and req=0, set wb_en<=0 and hold sel, wb_rd, wb_data, ptr.
REQ-020 SHALL, on an edge with stall=1, hold all registers (ptr, sel, wb_en, wb_rd, wb_data) unchanged regardless of req.
REQ-021 SHALL let a requester not granted keep req high; it is serviced no later than 3 grants after it first asserts req with stall low (no starvation).
REQ-022 SHALL wrap ptr from 3 to 0 on grant to requester 3.
REQ-023 SHALL treat req changes in the same cycle as stall deassertion normally: grant evaluated on current req when stall=0.

Reset
REQ-024 SHALL, while reset=1, asynchronously force ptr=0, sel=0, wb_en=0, wb_rd=0, wb_data=0.
REQ-025 SHALL drive gnt=0 while reset=1, independent of req and stall.
REQ-026 SHALL, on reset asserted mid-operation, discard any output pending; first grant after release follows ptr=0 priority.

Verification
REQ-027 SHALL pass: reset, req=4'b0100, rd2=5, d2=0xAA, stall=0 -> gnt=4'b0100 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0xAA, sel=2; ptr=3.
REQ-028 SHALL pass: reset, req=4'b1111 held 5 cycles, all rd!=0 -> grants 0,1,2,3,0 in order; sel follows 0,1,2,3,0 one cycle later.
REQ-029 SHALL pass: grant to 1 with rd1=0 -> next cycle wb_en=0, wb_rd=0, sel=1; ptr=2.
REQ-030 SHALL pass: wb_en=1 from prior grant, then stall=1 with req=4'b0011 for 3 cycles -> gnt=0 throughout, wb_en/wb_rd/wb_data/sel unchanged; after stall=0, grant goes to ptr-priority requester.
REQ-031 SHALL pass: ptr=2, req=4'b1001 -> gnt=4'b1000, then ptr=0 and next grant to requester 0.
REQ-032 SHALL pass: reset pulsed asynchronously between edges while wb_en=1 -> wb_en=0 and all outputs 0 immediately, without waiting for clk.
